// File: rtl/pico_mem_bridge.sv
// pico_mem_bridge: bridges a PicoRV32-style native memory port onto separate
// instruction and data request/grant/valid memory ports, one transfer at a time.
// Optional response watchdog enabled by defining PICO_MEM_BRIDGE_TIMEOUT_EN.
module pico_mem_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pico_valid_i,
    input  logic                    pico_instr_i,
    input  logic [ADDR_WIDTH-1:0]   pico_addr_i,
    input  logic [DATA_WIDTH-1:0]   pico_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] pico_wstrb_i,
    output logic                    pico_ready_o,
    output logic [DATA_WIDTH-1:0]   pico_rdata_o,
    output logic                    instr_mem_req_o,
    input  logic                    instr_mem_gnt_i,
    input  logic                    instr_mem_valid_i,
    output logic [ADDR_WIDTH-1:0]   instr_mem_addr_o,
    input  logic [DATA_WIDTH-1:0]   instr_mem_rdata_i,
    input  logic                    instr_mem_error_i,
    output logic                    data_mem_req_o,
    input  logic                    data_mem_gnt_i,
    input  logic                    data_mem_valid_i,
    output logic [ADDR_WIDTH-1:0]   data_mem_addr_o,
    output logic                    data_mem_we_o,
    output logic [DATA_WIDTH/8-1:0] data_mem_be_o,
    output logic [DATA_WIDTH-1:0]   data_mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_mem_rdata_i,
    input  logic                    data_mem_error_i,
    output logic                    bus_error_o,
    output logic [ADDR_WIDTH-1:0]   error_addr_o,
    output logic                    error_instr_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   wstrb_q;
    logic                  instr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] error_addr_q;
    logic                  error_instr_q;

    logic                  sel_gnt;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_error;
    logic                  capture_resp;
    logic                  start;

`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic                  timeout;
    logic                  capture_timeout;

    // The last WAIT cycle before the limit is the one where the count hits TIMEOUT_CYCLES-1
    assign timeout = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

    // Only the side picked by the latched fetch flag is ever listened to
    assign sel_gnt   = instr_q ? instr_mem_gnt_i   : data_mem_gnt_i;
    assign sel_valid = instr_q ? instr_mem_valid_i : data_mem_valid_i;
    assign sel_rdata = instr_q ? instr_mem_rdata_i : data_mem_rdata_i;
    assign sel_error = instr_q ? instr_mem_error_i : data_mem_error_i;
    assign start     = (state == IDLE) && pico_valid_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and response capture strobes
    always_comb begin
        state_next   = state;
        capture_resp = 1'b0;
`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
        capture_timeout = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pico_valid_i) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (sel_gnt) begin
                    if (sel_valid) begin
                        state_next   = DONE;
                        capture_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (sel_valid) begin
                    state_next   = DONE;
                    capture_resp = 1'b1;
                end
`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
                else if (timeout) begin
                    state_next      = DONE;
                    capture_timeout = 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, response latch and sticky error report registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            instr_q       <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            error_addr_q  <= '0;
            error_instr_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= pico_addr_i;
                wdata_q <= pico_wdata_i;
                wstrb_q <= pico_wstrb_i;
                instr_q <= pico_instr_i;
            end
            if (capture_resp) begin
                rdata_q <= sel_rdata;
                err_q   <= sel_error;
                if (sel_error) begin
                    error_addr_q  <= addr_q;
                    error_instr_q <= instr_q;
                end
            end
`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
            if (capture_timeout) begin
                rdata_q       <= '0;
                err_q         <= 1'b1;
                error_addr_q  <= addr_q;
                error_instr_q <= instr_q;
            end
`endif
        end
    end

`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
    // Watchdog counter: cleared while requesting so it starts at zero in the first WAIT cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == REQ) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
    end
`endif

    assign instr_mem_req_o  = (state == REQ) && instr_q;
    assign instr_mem_addr_o = addr_q;

    assign data_mem_req_o   = (state == REQ) && !instr_q;
    assign data_mem_addr_o  = addr_q;
    assign data_mem_we_o    = data_mem_req_o && (|wstrb_q);
    assign data_mem_be_o    = data_mem_req_o ? ((|wstrb_q) ? wstrb_q : {BE_WIDTH{1'b1}}) : '0;
    assign data_mem_wdata_o = wdata_q;

    assign pico_ready_o     = (state == DONE);
    assign pico_rdata_o     = ((state == DONE) && !err_q) ? rdata_q : '0;
    assign bus_error_o      = (state == DONE) && err_q;
    assign error_addr_o     = error_addr_q;
    assign error_instr_o    = error_instr_q;

endmodule

// File: tb/tb_pico_mem_bridge.sv
// tb_pico_mem_bridge: cycle-by-cycle vector table for the main transfer shapes,
// plus hand sequences for reset during WAIT and the response watchdog.
module tb_pico_mem_bridge;

    localparam logic        O = 1'b0;
    localparam logic        I = 1'b1;
    localparam logic [31:0] Z = 32'h0;

    logic        clk_i;
    logic        rst_ni;
    logic        pico_valid_i;
    logic        pico_instr_i;
    logic [31:0] pico_addr_i;
    logic [31:0] pico_wdata_i;
    logic [3:0]  pico_wstrb_i;
    logic        pico_ready_o;
    logic [31:0] pico_rdata_o;
    logic        instr_mem_req_o;
    logic        instr_mem_gnt_i;
    logic        instr_mem_valid_i;
    logic [31:0] instr_mem_addr_o;
    logic [31:0] instr_mem_rdata_i;
    logic        instr_mem_error_i;
    logic        data_mem_req_o;
    logic        data_mem_gnt_i;
    logic        data_mem_valid_i;
    logic [31:0] data_mem_addr_o;
    logic        data_mem_we_o;
    logic [3:0]  data_mem_be_o;
    logic [31:0] data_mem_wdata_o;
    logic [31:0] data_mem_rdata_i;
    logic        data_mem_error_i;
    logic        bus_error_o;
    logic [31:0] error_addr_o;
    logic        error_instr_o;

    int checks   = 0;
    int failures = 0;

    // One record = what is driven during a cycle and what the outputs must show in that cycle
    typedef struct {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        ig;
        logic        iv;
        logic        ie;
        logic [31:0] ird;
        logic        dg;
        logic        dv;
        logic        de;
        logic [31:0] drd;
        logic        x_ireq;
        logic        x_dreq;
        logic        x_we;
        logic [3:0]  x_be;
        logic        x_ready;
        logic [31:0] x_rdata;
        logic        x_berr;
        logic [31:0] x_eaddr;
        logic        x_einstr;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
    } vec_t;

    vec_t vecs[$];

    pico_mem_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .pico_valid_i      (pico_valid_i),
        .pico_instr_i      (pico_instr_i),
        .pico_addr_i       (pico_addr_i),
        .pico_wdata_i      (pico_wdata_i),
        .pico_wstrb_i      (pico_wstrb_i),
        .pico_ready_o      (pico_ready_o),
        .pico_rdata_o      (pico_rdata_o),
        .instr_mem_req_o   (instr_mem_req_o),
        .instr_mem_gnt_i   (instr_mem_gnt_i),
        .instr_mem_valid_i (instr_mem_valid_i),
        .instr_mem_addr_o  (instr_mem_addr_o),
        .instr_mem_rdata_i (instr_mem_rdata_i),
        .instr_mem_error_i (instr_mem_error_i),
        .data_mem_req_o    (data_mem_req_o),
        .data_mem_gnt_i    (data_mem_gnt_i),
        .data_mem_valid_i  (data_mem_valid_i),
        .data_mem_addr_o   (data_mem_addr_o),
        .data_mem_we_o     (data_mem_we_o),
        .data_mem_be_o     (data_mem_be_o),
        .data_mem_wdata_o  (data_mem_wdata_o),
        .data_mem_rdata_i  (data_mem_rdata_i),
        .data_mem_error_i  (data_mem_error_i),
        .bus_error_o       (bus_error_o),
        .error_addr_o      (error_addr_o),
        .error_instr_o     (error_instr_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pico_valid_i      = v.valid;
        pico_instr_i      = v.instr;
        pico_addr_i       = v.addr;
        pico_wdata_i      = v.wdata;
        pico_wstrb_i      = v.wstrb;
        instr_mem_gnt_i   = v.ig;
        instr_mem_valid_i = v.iv;
        instr_mem_error_i = v.ie;
        instr_mem_rdata_i = v.ird;
        data_mem_gnt_i    = v.dg;
        data_mem_valid_i  = v.dv;
        data_mem_error_i  = v.de;
        data_mem_rdata_i  = v.drd;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check("instr_req", idx, 32'(instr_mem_req_o), 32'(v.x_ireq));
        check("data_req", idx, 32'(data_mem_req_o), 32'(v.x_dreq));
        check("ready", idx, 32'(pico_ready_o), 32'(v.x_ready));
        check("rdata", idx, pico_rdata_o, v.x_rdata);
        check("bus_error", idx, 32'(bus_error_o), 32'(v.x_berr));
        check("error_addr", idx, error_addr_o, v.x_eaddr);
        check("error_instr", idx, 32'(error_instr_o), 32'(v.x_einstr));
        if (v.x_ireq) begin
            check("instr_addr", idx, instr_mem_addr_o, v.x_addr);
        end
        if (v.x_dreq) begin
            check("data_addr", idx, data_mem_addr_o, v.x_addr);
            check("data_we", idx, 32'(data_mem_we_o), 32'(v.x_we));
            check("data_be", idx, 32'(data_mem_be_o), 32'(v.x_be));
            if (v.x_we) begin
                check("data_wdata", idx, data_mem_wdata_o, v.x_wdata);
            end
        end
    endtask

    task automatic idleInputs();
        vec_t v;
        v = '{O,O,Z,Z,4'h0, O,O,O,Z, O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z};
        applyStimulus(v);
    endtask

    initial begin
        // Field order: valid instr addr wdata wstrb | ig iv ie ird | dg dv de drd |
        //              x_ireq x_dreq x_we x_be x_ready x_rdata x_berr x_eaddr x_einstr | x_addr x_wdata
        // Fetch at 0x100, granted and answered in the REQ cycle
        vecs.push_back('{I,I,32'h100,Z,4'h0, O,O,O,Z,     O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       I,I,O,32'h13, O,O,O,Z, I,O,O,4'h0,O,Z,O,Z,O, 32'h100,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       O,O,O,Z,     O,O,O,Z, O,O,O,4'h0,I,32'h13,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       O,O,O,Z,     O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        // Half-word store to 0x2000, grant on the fifth REQ cycle, valid two cycles later
        vecs.push_back('{I,O,32'h2000,32'hDEADBEEF,4'h3, O,O,O,Z, O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        for (int k = 0; k < 4; k++) begin
            vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, O,O,O,Z, O,I,I,4'h3,O,Z,O,Z,O, 32'h2000,32'hDEADBEEF});
        end
        vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, I,O,O,Z, O,I,I,4'h3,O,Z,O,Z,O, 32'h2000,32'hDEADBEEF});
        vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, O,I,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, O,O,O,Z, O,O,O,4'h0,I,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0, O,O,O,Z, O,O,O,Z, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        // Data read at 0x3000 answered with an error
        vecs.push_back('{I,O,32'h3000,Z,4'h0, O,O,O,Z, O,O,O,Z,           O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, I,O,O,Z,           O,I,O,4'hF,O,Z,O,Z,O, 32'h3000,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,I,I,32'h55AA55AA, O,O,O,4'h0,O,Z,O,Z,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,O,O,Z,           O,O,O,4'h0,I,Z,I,32'h3000,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,O,O,Z,           O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        // Data read at 0x4000 with instruction-side noise and core requests held high meanwhile
        vecs.push_back('{I,O,32'h4000,Z,4'h0, O,I,O,32'hBAD, O,O,O,Z, O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        vecs.push_back('{I,I,32'h9999,Z,4'hF, I,I,O,32'hBAD, O,O,O,Z, O,I,O,4'hF,O,Z,O,32'h3000,O, 32'h4000,Z});
        vecs.push_back('{I,I,32'h9999,Z,4'hF, I,I,O,32'hBAD, I,O,O,Z, O,I,O,4'hF,O,Z,O,32'h3000,O, 32'h4000,Z});
        vecs.push_back('{I,O,32'h8888,Z,4'h0, I,I,I,32'hBAD, O,O,O,Z, O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,I,O,32'h12345678, O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,O,O,Z, O,O,O,4'h0,I,32'h12345678,O,32'h3000,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,        O,O,O,Z, O,O,O,Z, O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        // Fetch at 0x500 answered with an error in the REQ cycle
        vecs.push_back('{I,I,32'h500,Z,4'h0, O,O,O,Z,           O,O,O,Z, O,O,O,4'h0,O,Z,O,32'h3000,O, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       I,I,I,32'hFFFFFFFF, O,O,O,Z, I,O,O,4'h0,O,Z,O,32'h3000,O, 32'h500,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       O,O,O,Z,           O,O,O,Z, O,O,O,4'h0,I,Z,I,32'h500,I, Z,Z});
        vecs.push_back('{O,O,Z,Z,4'h0,       O,O,O,Z,           O,O,O,Z, O,O,O,4'h0,O,Z,O,32'h500,I, Z,Z});

        rst_ni = 1'b0;
        idleInputs();
        tick();
        tick();
        check("reset_ready", 0, 32'(pico_ready_o), 32'h0);
        check("reset_ireq", 0, 32'(instr_mem_req_o), 32'h0);
        check("reset_dreq", 0, 32'(data_mem_req_o), 32'h0);
        check("reset_we", 0, 32'(data_mem_we_o), 32'h0);
        check("reset_berr", 0, 32'(bus_error_o), 32'h0);
        check("reset_eaddr", 0, error_addr_o, 32'h0);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i + 1);
            tick();
        end

        // Reset while waiting on a data read, then a late response that must be dropped
        idleInputs();
        pico_valid_i = 1'b1;
        pico_addr_i  = 32'h6000;
        tick();
        pico_valid_i   = 1'b0;
        data_mem_gnt_i = 1'b1;
        tick();
        data_mem_gnt_i = 1'b0;
        tick();
        check("wait_before_reset", 100, 32'(pico_ready_o), 32'h0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("rst_ready", 101, 32'(pico_ready_o), 32'h0);
        check("rst_dreq", 101, 32'(data_mem_req_o), 32'h0);
        check("rst_berr", 101, 32'(bus_error_o), 32'h0);
        check("rst_eaddr", 101, error_addr_o, 32'h0);
        check("rst_einstr", 101, 32'(error_instr_o), 32'h0);
        check("rst_rdata", 101, pico_rdata_o, 32'h0);
        data_mem_valid_i = 1'b1;
        data_mem_rdata_i = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("late_valid_ready", 102 + k, 32'(pico_ready_o), 32'h0);
            check("late_valid_rdata", 102 + k, pico_rdata_o, 32'h0);
        end
        idleInputs();
        tick();

        // Granted data read at 0x7000 that never gets a valid
        pico_valid_i = 1'b1;
        pico_addr_i  = 32'h7000;
        tick();
        pico_valid_i   = 1'b0;
        data_mem_gnt_i = 1'b1;
        tick();
        data_mem_gnt_i = 1'b0;
`ifdef PICO_MEM_BRIDGE_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            check("timeout_early_ready", 200 + k, 32'(pico_ready_o), 32'h0);
            tick();
        end
        check("timeout_ready", 209, 32'(pico_ready_o), 32'h1);
        check("timeout_berr", 209, 32'(bus_error_o), 32'h1);
        check("timeout_rdata", 209, pico_rdata_o, 32'h0);
        check("timeout_eaddr", 209, error_addr_o, 32'h7000);
        check("timeout_einstr", 209, 32'(error_instr_o), 32'h0);
        tick();
        check("timeout_after", 210, 32'(pico_ready_o), 32'h0);
`else
        begin
            int ready_seen;
            ready_seen = 0;
            for (int k = 0; k < 1000; k++) begin
                if (pico_ready_o) ready_seen++;
                tick();
            end
            check("no_timeout_ready_count", 200, ready_seen, 32'h0);
            check("no_timeout_berr", 201, 32'(bus_error_o), 32'h0);
        end
`endif
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pico_mem_bridge.md
PICO_MEM_BRIDGE -- requirements
Module: pico_mem_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address width of all ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width (a multiple of 8); BE width = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256 (min 2), giving the response watchdog limit in cycles.
REQ-004 One clock; reset is synchronous and active-low: clk_i  in  1  clock; rst_ni  in  1  synchronous active-low reset.
REQ-005 The core-side ports SHALL be:
- pico_valid_i  in  1  transfer request
- pico_instr_i  in  1  fetch flag
- pico_addr_i  in  ADDR_WIDTH  address
- pico_wdata_i  in  DATA_WIDTH  write data
- pico_wstrb_i  in  BE  write strobes (0 = read)
- pico_ready_o  out  1  completion pulse
- pico_rdata_o  out  DATA_WIDTH  read data
REQ-006 The instruction-side ports SHALL be:
- instr_mem_req_o  out  1
- instr_mem_gnt_i  in  1
- instr_mem_valid_i  in  1
- instr_mem_addr_o  out  ADDR_WIDTH
- instr_mem_rdata_i  in  DATA_WIDTH
- instr_mem_error_i  in  1
REQ-007 The data-side ports SHALL be:
- data_mem_req_o  out  1
- data_mem_gnt_i  in  1
- data_mem_valid_i  in  1
- data_mem_addr_o  out  ADDR_WIDTH
- data_mem_we_o  out  1
- data_mem_be_o  out  BE
- data_mem_wdata_o  out  DATA_WIDTH
- data_mem_rdata_i  in  DATA_WIDTH
- data_mem_error_i  in  1
REQ-008 The status ports SHALL be:
- bus_error_o  out  1  one-cycle error pulse
- error_addr_o  out  ADDR_WIDTH  address of the last failed transfer
- error_instr_o  out  1  side of the last failed transfer (1 = instruction)

Function
REQ-009 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-010 IDLE, pico_valid_i=1: the block SHALL latch addr, wdata, wstrb and instr, then go to REQ the next cycle.
REQ-011 REQ: the block SHALL assert only the selected side's req from the latched values (we = |wstrb; be = wstrb, or all-ones for reads), holding them until gnt=1.
REQ-012 gnt=1 in REQ: req SHALL drop the next cycle; if valid=1 in the same cycle, go to DONE, else go to WAIT.
REQ-013 WAIT, selected side valid=1: the block SHALL latch rdata and error, then go to DONE.
REQ-014 DONE: pico_ready_o=1 for exactly one cycle with the latched rdata, then go to IDLE; latency from IDLE request to ready SHALL be 3 cycles minimum (zero-wait memory).
REQ-015 An error response SHALL force pico_rdata_o to 0, pulse bus_error_o in the DONE cycle, and update error_addr_o and error_instr_o.
REQ-016 pico_rdata_o SHALL be 0 whenever pico_ready_o=0.
REQ-017 valid/gnt on the non-selected side, and valid in IDLE or REQ, SHALL be ignored.
REQ-018 pico_valid_i changes outside IDLE SHALL be ignored (one outstanding transfer).

Reset
REQ-019 rst_ni=0 at a clock edge SHALL force IDLE, all req/we/ready/bus_error outputs to 0, and all address, data and error registers to 0, including mid-transfer.
REQ-020 A response arriving after reset for an abandoned transfer SHALL be ignored.

Configuration
REQ-021 With macro PICO_MEM_BRIDGE_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT; if it reaches TIMEOUT_CYCLES without valid, the block SHALL go to DONE as an error response.
REQ-022 Without PICO_MEM_BRIDGE_TIMEOUT_EN, the block SHALL contain no counter logic and WAIT SHALL persist indefinitely.

Verification
REQ-023 Fetch at 0x100 with gnt and valid=1 in the REQ cycle, rdata 0x00000013 -> instr_mem_req_o high for 1 cycle; pico_ready_o 3 cycles after pico_valid_i with rdata 0x00000013; data side idle.
REQ-024 Store of 0xDEADBEEF to 0x2000, wstrb 0b0011, gnt delayed 4 cycles, valid 2 cycles after gnt -> req held 5 cycles; we=1; be=0b0011; addr and wdata stable; single ready pulse.
REQ-025 Data read at 0x3000 with data_mem_error_i=1 -> pico_rdata_o=0, bus_error_o pulse, error_addr_o=0x3000, error_instr_o=0.
REQ-026 rst_ni low during WAIT, then valid returned -> outputs 0 after reset; late valid produces no pico_ready_o.
REQ-027 With PICO_MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, a granted read that never gets valid -> ready and bus_error_o on the 9th cycle after entering WAIT; without the macro, no ready after 1000 cycles.
REQ-028 instr_mem_valid_i pulsed during a data transfer -> ignored; the data transfer completes normally.
